// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access sizes,
// AXI response codes, fault codes and the natural-alignment helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RESP,
        WR_REQ,
        WR_RESP,
        DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } lsu_size_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_BUS      = 2'd2;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // A dword access cannot be carried by a 32-bit data bus at all.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lo,
                                           input int unsigned data_w);
        return ((lo & align_mask(size)) != 3'b000) || (size == 2'd3 && data_w == 32);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store strobe/data placement and load extract with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB = DATA_W / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  lsu_size_e          size_i,
    input  logic [OFF_W-1:0]   off_i,
    input  logic               uns_i,
    input  logic [DATA_W-1:0]  st_data_i,
    input  logic [DATA_W-1:0]  rdata_i,
    output logic [NB-1:0]      wstrb_o,
    output logic [DATA_W-1:0]  wdata_o,
    output logic [DATA_W-1:0]  ld_o
);

    logic [OFF_W+2:0]  bit_off;
    logic [NB-1:0]     strb_base;
    logic [DATA_W-1:0] rd_sh;
    logic [63:0]       rd64;
    logic [63:0]       ld64;

    always_comb begin
        bit_off = {off_i, 3'b000};
        case (size_i)
            SIZE_B:  strb_base = NB'(8'h01);
            SIZE_H:  strb_base = NB'(8'h03);
            SIZE_W:  strb_base = NB'(8'h0F);
            default: strb_base = NB'(8'hFF);
        endcase
        wstrb_o = strb_base << off_i;
        wdata_o = st_data_i << bit_off;

        // Work at 64 bits so every size extends from its own top bit on either bus width.
        rd_sh = rdata_i >> bit_off;
        rd64  = 64'(rd_sh);
        case (size_i)
            SIZE_B:  ld64 = uns_i ? 64'(rd64[7:0])  : 64'($signed(rd64[7:0]));
            SIZE_H:  ld64 = uns_i ? 64'(rd64[15:0]) : 64'($signed(rd64[15:0]));
            SIZE_W:  ld64 = uns_i ? 64'(rd64[31:0]) : 64'($signed(rd64[31:0]));
            default: ld64 = rd64;
        endcase
        ld_o = ld64[DATA_W-1:0];
    end

endmodule

// File: rtl/lsu_axi_fsm.sv
// Load/store unit between EX and WB: one op per handshake, sequenced over an AXI-lite
// master port (AR/R for loads, independent AW and W then B for stores).
module lsu_axi_fsm
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CHK_ALIGN = 1,
    localparam int NB = DATA_W / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prev_valid,
    output logic              this_ready,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              this_valid,
    input  logic              next_ready,
    output logic [DATA_W-1:0] ld_data,
    output logic [1:0]        fault,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [NB-1:0]     wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    lsu_state_e        state_q, state_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [DATA_W-1:0] ld_q, ld_d;
    logic [1:0]        fault_q, fault_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    lsu_size_e         size_q, size_d;
    logic              uns_q, uns_d;
    logic [DATA_W-1:0] st_q, st_d;

    logic              mis;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] ld_ext;

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .size_i    (size_q),
        .off_i     (addr_q[OFF_W-1:0]),
        .uns_i     (uns_q),
        .st_data_i (st_q),
        .rdata_i   (rdata),
        .wstrb_o   (wstrb),
        .wdata_o   (wdata),
        .ld_o      (ld_ext)
    );

    // With checking disabled the address is silently rounded down to natural alignment.
    assign mis     = (CHK_ALIGN != 0) && (mem_rd || mem_wr)
                     && is_misaligned(size, addr[2:0], 32'(DATA_W));
    assign addr_in = (CHK_ALIGN != 0) ? addr
                     : {addr[ADDR_W-1:3], addr[2:0] & ~align_mask(size)};

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        ld_d      = ld_q;
        fault_d   = fault_q;
        addr_d    = addr_q;
        size_d    = size_q;
        uns_d     = uns_q;
        st_d      = st_q;
        case (state_q)
            IDLE: begin
                if (prev_valid) begin
                    addr_d    = addr_in;
                    size_d    = lsu_size_e'(size);
                    uns_d     = is_unsigned;
                    st_d      = st_data;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    ld_d      = '0;
                    fault_d   = mis ? FAULT_MISALIGN : FAULT_NONE;
                    if (mis)         state_d = DONE;
                    else if (mem_rd) state_d = RD_REQ;
                    else if (mem_wr) state_d = WR_REQ;
                    else             state_d = DONE;
                end
            end
            RD_REQ: begin
                if (arready) state_d = RD_RESP;
            end
            RD_RESP: begin
                if (rvalid) begin
                    if (rresp != AXI_RESP_OKAY) fault_d = FAULT_BUS;
                    else                        ld_d    = ld_ext;
                    state_d = DONE;
                end
            end
            WR_REQ: begin
                // Each channel retires on its own ready; both may land in one cycle.
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (bvalid) begin
                    if (bresp != AXI_RESP_OKAY) fault_d = FAULT_BUS;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (next_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ld_q      <= '0;
            fault_q   <= FAULT_NONE;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ld_q      <= ld_d;
            fault_q   <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        size_q <= size_d;
        uns_q  <= uns_d;
        st_q   <= st_d;
    end

    // Handshake outputs decode straight from state so reset clears them asynchronously.
    assign this_ready = (state_q == IDLE);
    assign this_valid = (state_q == DONE);
    assign arvalid    = (state_q == RD_REQ);
    assign rready     = (state_q == RD_RESP);
    assign awvalid    = (state_q == WR_REQ) && !aw_done_q;
    assign wvalid     = (state_q == WR_REQ) && !w_done_q;
    assign bready     = (state_q == WR_RESP);
    assign araddr     = addr_q;
    assign awaddr     = addr_q;
    assign ld_data    = ld_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_lsu_axi_fsm.sv
// Bench for lsu_axi_fsm: a 32-bit and a 64-bit instance share one stimulus/slave model, selected by sel.
module tb_lsu_axi_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sel;
    logic        prev_valid, mem_rd, mem_wr, is_unsigned, next_ready;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [63:0] st_data, rdata;
    logic        arready, rvalid, awready, wready, bvalid;
    logic [1:0]  rresp, bresp;

    logic        r32_tr, r32_tv, r32_arv, r32_rr, r32_awv, r32_wv, r32_br;
    logic [31:0] r32_ld, r32_ara, r32_awa, r32_wd;
    logic [3:0]  r32_ws;
    logic [1:0]  r32_f;
    logic        r64_tr, r64_tv, r64_arv, r64_rr, r64_awv, r64_wv, r64_br;
    logic [63:0] r64_ld, r64_wd;
    logic [31:0] r64_ara, r64_awa;
    logic [7:0]  r64_ws;
    logic [1:0]  r64_f;

    logic        o_this_ready, o_this_valid, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready;
    logic [63:0] o_ld, o_wdata;
    logic [31:0] o_araddr, o_awaddr;
    logic [7:0]  o_wstrb;
    logic [1:0]  o_fault;

    assign o_this_ready = sel ? r64_tr  : r32_tr;
    assign o_this_valid = sel ? r64_tv  : r32_tv;
    assign o_arvalid    = sel ? r64_arv : r32_arv;
    assign o_rready     = sel ? r64_rr  : r32_rr;
    assign o_awvalid    = sel ? r64_awv : r32_awv;
    assign o_wvalid     = sel ? r64_wv  : r32_wv;
    assign o_bready     = sel ? r64_br  : r32_br;
    assign o_ld         = sel ? r64_ld  : {32'b0, r32_ld};
    assign o_wdata      = sel ? r64_wd  : {32'b0, r32_wd};
    assign o_araddr     = sel ? r64_ara : r32_ara;
    assign o_awaddr     = sel ? r64_awa : r32_awa;
    assign o_wstrb      = sel ? r64_ws  : {4'b0, r32_ws};
    assign o_fault      = sel ? r64_f   : r32_f;

    lsu_axi_fsm #(.ADDR_W(32), .DATA_W(32), .CHK_ALIGN(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .prev_valid(prev_valid & ~sel), .this_ready(r32_tr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .size(size), .is_unsigned(is_unsigned),
        .addr(addr), .st_data(st_data[31:0]), .this_valid(r32_tv), .next_ready(next_ready),
        .ld_data(r32_ld), .fault(r32_f),
        .araddr(r32_ara), .arvalid(r32_arv), .arready(arready),
        .rdata(rdata[31:0]), .rresp(rresp), .rvalid(rvalid), .rready(r32_rr),
        .awaddr(r32_awa), .awvalid(r32_awv), .awready(awready),
        .wdata(r32_wd), .wstrb(r32_ws), .wvalid(r32_wv), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(r32_br)
    );

    lsu_axi_fsm #(.ADDR_W(32), .DATA_W(64), .CHK_ALIGN(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .prev_valid(prev_valid & sel), .this_ready(r64_tr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .size(size), .is_unsigned(is_unsigned),
        .addr(addr), .st_data(st_data), .this_valid(r64_tv), .next_ready(next_ready),
        .ld_data(r64_ld), .fault(r64_f),
        .araddr(r64_ara), .arvalid(r64_arv), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(r64_rr),
        .awaddr(r64_awa), .awvalid(r64_awv), .awready(awready),
        .wdata(r64_wd), .wstrb(r64_ws), .wvalid(r64_wv), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(r64_br)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] last_ld, last_wdata;
    logic [7:0]  last_wstrb;
    logic [1:0]  last_fault;
    int          last_lat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference rules: lane offset is addr mod bus bytes; access width is 2^size bytes.
    function automatic bit ref_mis(input int dw, input logic [31:0] a, input int sz);
        return (sz == 3 && dw == 32) || ((a % (32'd1 << sz)) != 0);
    endfunction

    function automatic logic [63:0] ref_ld(input int dw, input logic [31:0] a, input int sz,
                                           input bit uns, input logic [63:0] rd);
        int off, nbits;
        logic [63:0] v, m;
        off   = int'(a % (dw / 8));
        nbits = 8 << sz;
        v = (dw == 32) ? (rd & 64'hFFFF_FFFF) : rd;
        v = v >> (8 * off);
        m = (nbits == 64) ? '1 : ((64'd1 << nbits) - 64'd1);
        v = v & m;
        if (!uns && v[nbits-1]) v = v | ~m;
        return (dw == 32) ? (v & 64'hFFFF_FFFF) : v;
    endfunction

    function automatic logic [7:0] ref_strb(input int dw, input logic [31:0] a, input int sz);
        logic [63:0] m;
        m = ((64'd1 << (1 << sz)) - 64'd1) << (a % (dw / 8));
        return (dw == 32) ? {4'b0, m[3:0]} : m[7:0];
    endfunction

    function automatic logic [63:0] ref_wdata(input int dw, input logic [31:0] a, input logic [63:0] st);
        logic [63:0] v;
        v = (dw == 32) ? (st & 64'hFFFF_FFFF) : st;
        v = v << (8 * (a % (dw / 8)));
        return (dw == 32) ? (v & 64'hFFFF_FFFF) : v;
    endfunction

    // kind: 0 non-mem, 1 load, 2 store. Waits are slave stall cycles per channel.
    task automatic run_op(input bit s, input int kind, input int sz, input bit uns,
                          input logic [31:0] a, input logic [63:0] st, input logic [63:0] rd,
                          input logic [1:0] resp, input int arw, input int rw, input int aww,
                          input int ww, input int bw, input int nrw);
        int dw, lat;
        bit mis, got, r_arm, b_arm, b_started;
        int ar_hs, r_hs, aw_hs, w_hs, b_hs, ar_c, r_c, aw_c, w_c, b_c;
        logic [63:0] exp_ld;
        logic [1:0]  exp_fault;
        dw = s ? 64 : 32;
        mis = (kind != 0) && ref_mis(dw, a, sz);
        exp_ld = 64'd0;
        exp_fault = 2'd0;
        if (mis) exp_fault = 2'd1;
        else if (kind != 0 && resp != 2'b00) exp_fault = 2'd2;
        else if (kind == 1) exp_ld = ref_ld(dw, a, sz, uns, rd);
        got = 0; r_arm = 0; b_arm = 0; b_started = 0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;

        @(negedge clk);
        sel = s;
        #1;
        chk("ready_before_accept", o_this_ready, 1);
        prev_valid = 1; mem_rd = (kind == 1); mem_wr = (kind == 2);
        size = sz[1:0]; is_unsigned = uns; addr = a; st_data = st;
        @(negedge clk);
        prev_valid = 0; mem_rd = 0; mem_wr = 0;
        addr = $urandom; st_data = {$urandom, $urandom}; size = 2'($urandom_range(0, 3));
        lat = 1;
        while (lat < 100) begin
            if (o_this_valid) begin
                got = 1;
                break;
            end
            rvalid = 0; rdata = {$urandom, $urandom};
            if (r_arm) begin
                if (r_c == rw) begin
                    rvalid = 1; rdata = rd; rresp = resp;
                    if (o_rready) begin r_hs++; r_arm = 0; end
                end else r_c++;
            end
            arready = 0;
            if (o_arvalid) begin
                chk("araddr", o_araddr, a);
                if (ar_c == arw) begin arready = 1; ar_hs++; r_arm = 1; r_c = 0; end
                else ar_c++;
            end
            bvalid = 0;
            if (b_arm) begin
                if (b_c == bw) begin
                    bvalid = 1; bresp = resp;
                    if (o_bready) begin b_hs++; b_arm = 0; end
                end else b_c++;
            end
            awready = 0;
            if (o_awvalid) begin
                chk("awaddr", o_awaddr, a);
                if (aw_c == aww) begin awready = 1; aw_hs++; end
                else aw_c++;
            end
            wready = 0;
            if (o_wvalid) begin
                chk("wdata", o_wdata, ref_wdata(dw, a, st));
                chk("wstrb", o_wstrb, ref_strb(dw, a, sz));
                if (w_c == ww) begin
                    wready = 1; w_hs++; last_wdata = o_wdata; last_wstrb = o_wstrb;
                end else w_c++;
            end
            if (aw_hs > 0 && w_hs > 0 && !b_started) begin b_arm = 1; b_started = 1; b_c = 0; end
            @(negedge clk);
            lat++;
        end
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        chk("result_arrived", got, 1);
        chk("ar_count", ar_hs, (kind == 1 && !mis) ? 1 : 0);
        chk("r_count",  r_hs,  (kind == 1 && !mis) ? 1 : 0);
        chk("aw_count", aw_hs, (kind == 2 && !mis) ? 1 : 0);
        chk("w_count",  w_hs,  (kind == 2 && !mis) ? 1 : 0);
        chk("b_count",  b_hs,  (kind == 2 && !mis) ? 1 : 0);
        if (kind == 0 || mis) chk("short_latency", lat, 1);
        chk("ld_data", o_ld, exp_ld);
        chk("fault", o_fault, exp_fault);
        chk("ready_in_done", o_this_ready, 0);
        last_ld = o_ld; last_fault = o_fault; last_lat = lat;
        for (int k = 0; k < nrw; k++) begin
            next_ready = 0;
            @(negedge clk);
            chk("hold_valid", o_this_valid, 1);
            chk("hold_ld", o_ld, exp_ld);
            chk("hold_fault", o_fault, exp_fault);
            chk("hold_ready", o_this_ready, 0);
        end
        next_ready = 1;
        @(negedge clk);
        next_ready = 0;
        chk("valid_dropped", o_this_valid, 0);
        chk("ready_after_ack", o_this_ready, 1);
        @(negedge clk);
        chk("valid_once", o_this_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; sel = 0; prev_valid = 0; mem_rd = 0; mem_wr = 0; is_unsigned = 0;
        next_ready = 0; size = 0; addr = 0; st_data = 0; rdata = 0;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; rresp = 0; bresp = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_this_ready", o_this_ready, 1);
            chk("rst_this_valid", o_this_valid, 0);
            chk("rst_arvalid", o_arvalid, 0);
            chk("rst_awvalid", o_awvalid, 0);
            chk("rst_wvalid", o_wvalid, 0);
            chk("rst_rready", o_rready, 0);
            chk("rst_bready", o_bready, 0);
            chk("rst_ld", o_ld, 0);
            chk("rst_fault", o_fault, 0);
        end
        @(negedge clk);
        rst_n = 1;

        run_op(0, 1, 0, 0, 32'h8000_0003, 64'd0, 64'h0000_0000_80AB_CDEF, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("t1_lb", last_ld, 64'h0000_0000_FFFF_FF80);
        run_op(0, 1, 0, 1, 32'h8000_0003, 64'd0, 64'h0000_0000_8012_3456, 2'b00, 1, 2, 0, 0, 0, 0);
        chk("t1_lbu", last_ld, 64'h0000_0000_0000_0080);

        run_op(0, 2, 1, 0, 32'h1000_0002, 64'h1234, 64'd0, 2'b00, 0, 0, 0, 2, 1, 0);
        chk("t2_wstrb", last_wstrb, 8'h0C);
        chk("t2_wdata", last_wdata, 64'h0000_0000_1234_0000);

        run_op(0, 1, 2, 0, 32'h2000_0002, 64'd0, 64'h1111_2222, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("t3_fault", last_fault, 2'd1);
        chk("t3_latency", last_lat, 1);

        run_op(1, 1, 3, 0, 32'h3000_0008, 64'd0, 64'hDEAD_BEEF_0123_4567, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("t4_ld", last_ld, 64'hDEAD_BEEF_0123_4567);
        run_op(1, 1, 2, 0, 32'h3000_0004, 64'd0, 64'hDEAD_BEEF_0123_4567, 2'b00, 0, 1, 0, 0, 0, 0);
        chk("t4_lw", last_ld, 64'hFFFF_FFFF_DEAD_BEEF);

        run_op(0, 1, 2, 0, 32'h4000_0000, 64'd0, 64'h0000_0000_5555_AAAA, 2'b10, 0, 0, 0, 0, 0, 5);
        chk("t5_fault", last_fault, 2'd2);
        chk("t5_ld", last_ld, 64'd0);

        run_op(0, 2, 2, 0, 32'h4000_0010, 64'hCAFE_F00D, 64'd0, 2'b11, 0, 0, 0, 0, 2, 0);
        chk("store_decerr", last_fault, 2'd2);
        run_op(1, 2, 0, 0, 32'h5000_0005, 64'h00A5, 64'd0, 2'b00, 0, 0, 0, 0, 0, 0);
        run_op(1, 2, 3, 0, 32'h5000_0010, 64'h0123_4567_89AB_CDEF, 64'd0, 2'b00, 0, 0, 3, 0, 0, 1);
        run_op(0, 1, 3, 0, 32'h6000_0000, 64'd0, 64'h1, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("dword_on_32", last_fault, 2'd1);
        run_op(0, 0, 2, 0, 32'h7000_0001, 64'd0, 64'd0, 2'b00, 0, 0, 0, 0, 0, 2);

        // Reset while AR is stalled.
        @(negedge clk);
        sel = 0; prev_valid = 1; mem_rd = 1; size = 2'd2; addr = 32'h0000_0100;
        @(negedge clk);
        prev_valid = 0; mem_rd = 0; arready = 0;
        @(negedge clk);
        chk("rst6_arvalid_before", o_arvalid, 1);
        #2 rst_n = 0;
        #1;
        chk("rst6_arvalid_async", o_arvalid, 0);
        chk("rst6_idle", o_this_ready, 1);
        chk("rst6_valid", o_this_valid, 0);
        @(negedge clk);
        rst_n = 1; arready = 1; rvalid = 1; rresp = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst6_no_valid", o_this_valid, 0);
            chk("rst6_no_ar", o_arvalid, 0);
        end
        arready = 0; rvalid = 0;

        for (int i = 0; i < 60; i++) begin
            bit s, uns;
            int kind, sz;
            logic [31:0] a;
            logic [1:0] resp;
            s = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 2);
            sz = $urandom_range(0, 3);
            uns = 1'($urandom_range(0, 1));
            a = $urandom & 32'hFFFF_FFF8;
            a = a | 32'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            resp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_op(s, kind, sz, uns, a, {$urandom, $urandom}, {$urandom, $urandom}, resp,
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
